// File: rtl/mole_pkg.sv
// Shared constants, state encoding and small helpers for the mole generator
// and anything downstream that decodes moleHit codes.
package mole_pkg;

    localparam int          NUM_HOLES         = 5;
    localparam logic [2:0]  HIT_NONE          = 3'd0;
    localparam logic [2:0]  HIT_MIN           = 3'd1;
    localparam logic [2:0]  HIT_MAX           = 3'd5;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10 of a left-shifting register
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } gen_state_t;

    function automatic logic [2:0] start_hole(input logic [2:0] raw);
        return (raw >= 3'd5) ? raw - 3'd5 : raw;
    endfunction

    // One-hot of the first free hole scanning upward from start, wrapping at NUM_HOLES.
    function automatic logic [NUM_HOLES-1:0] pick_free(input logic [NUM_HOLES-1:0] busy,
                                                       input logic [2:0]           start);
        logic [NUM_HOLES-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_HOLES) idx = idx - NUM_HOLES;
            if (!found && !busy[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] popcount_holes(input logic [NUM_HOLES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int k = 0; k < NUM_HOLES; k++) c = c + {2'b00, v[k]};
        return c;
    endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is replaced by the default
// so the register can never lock up. Exposes the low OUT_W bits.
module mole_lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT,
    parameter int          OUT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    output logic [OUT_W-1:0] o_rand
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_SEED_DEFAULT : SEED;

    logic [15:0] r_state;
    logic        w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= INIT;
        end else begin
            r_state <= {r_state[14:0], w_feedback};
        end
    end

    assign o_rand = r_state[OUT_W-1:0];

endmodule

// File: rtl/mole_generator.sv
// Spawns moles at pseudo-random free holes, ages them per tick, clears on hit/expiry.
// Optional MOLE_SPEEDUP_EN shortens new-mole lifetime after every 4th spawn.
module mole_generator
    import mole_pkg::*;
#(
    parameter int          SPAWN_TICKS = 8,
    parameter int          LIFE_TICKS  = 12,
    parameter int          MAX_ACTIVE  = 3,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [2:0]           moleHit,
    output logic [NUM_HOLES-1:0] molesGenerated,
    output logic                 spawnPulse,
    output logic                 expirePulse,
    output logic [2:0]           activeCount
);

    localparam int              SC_W      = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(SPAWN_TICKS - 1);
    localparam logic [7:0]      LIFE_INIT = 8'(LIFE_TICKS);

    gen_state_t                      r_state;
    logic [SC_W-1:0]                 r_spawn_cnt;
    logic [NUM_HOLES-1:0]            r_mask;
    logic [NUM_HOLES-1:0][7:0]       r_life;
    logic                            r_spawn_pulse;
    logic                            r_expire_pulse;

    logic [2:0]                      w_rand;
    logic [2:0]                      w_count;
    logic                            w_hit_valid;
    logic [NUM_HOLES-1:0]            w_hit;
    logic [NUM_HOLES-1:0]            w_expire;
    logic [NUM_HOLES-1:0]            w_pick;
    logic [NUM_HOLES-1:0]            w_spawn_sel;
    logic [NUM_HOLES-1:0]            w_mask_next;
    logic [NUM_HOLES-1:0][7:0]       w_life_next;
    logic                            w_spawn_try;
    logic                            w_spawn_ok;
    logic [7:0]                      w_life_load;

    mole_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (3)
    ) u_lfsr (
        .i_clock (clock),
        .i_reset (reset),
        .o_rand  (w_rand)
    );

    // Spawn decisions use only start-of-cycle state, so a hole freed this cycle waits a cycle.
    assign w_count     = popcount_holes(r_mask);
    assign w_spawn_try = (r_state == RUN) && tick && (r_spawn_cnt == SC_LAST);
    assign w_pick      = pick_free(r_mask, start_hole(w_rand));
    assign w_spawn_ok  = w_spawn_try && (int'(w_count) < MAX_ACTIVE) && (|w_pick);
    assign w_spawn_sel = w_spawn_ok ? w_pick : '0;
    assign w_hit_valid = (moleHit >= HIT_MIN) && (moleHit <= HIT_MAX);

    generate
        for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
            assign w_hit[gi]       = w_hit_valid && r_mask[gi] && (moleHit == 3'(gi + 1));
            // A hit on the final tick wins: the hole clears but is not reported as expired.
            assign w_expire[gi]    = tick && r_mask[gi] && (r_life[gi] == 8'd1) && !w_hit[gi];
            assign w_mask_next[gi] = (r_mask[gi] && !w_hit[gi] && !w_expire[gi]) || w_spawn_sel[gi];
            assign w_life_next[gi] = w_hit[gi]              ? 8'd0 :
                                     w_spawn_sel[gi]        ? w_life_load :
                                     (tick && r_mask[gi])   ? r_life[gi] - 8'd1 :
                                                              r_life[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_life <= '0;
        end else begin
            r_mask <= w_mask_next;
            r_life <= w_life_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_spawn_cnt    <= '0;
            r_spawn_pulse  <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_spawn_pulse  <= w_spawn_ok;
            r_expire_pulse <= |w_expire;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state     <= RUN;
                        r_spawn_cnt <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        r_spawn_cnt <= (r_spawn_cnt == SC_LAST) ? '0 : r_spawn_cnt + 1'b1;
                    end
                    if (!enable) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (enable) begin
                        r_state     <= RUN;
                        r_spawn_cnt <= '0;
                    end else if (r_mask == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MOLE_SPEEDUP_EN
    logic [7:0] r_life_load;
    logic [1:0] r_spawn_quad;
    logic       w_to_idle;

    assign w_to_idle = (r_state == DRAIN) && !enable && (r_mask == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_life_load  <= LIFE_INIT;
            r_spawn_quad <= 2'd0;
        end else if (w_to_idle) begin
            r_life_load  <= LIFE_INIT;
            r_spawn_quad <= 2'd0;
        end else if (w_spawn_ok) begin
            r_spawn_quad <= r_spawn_quad + 2'd1;
            if ((r_spawn_quad == 2'd3) && (r_life_load > 8'd3)) begin
                r_life_load <= r_life_load - 8'd1;
            end
        end
    end

    assign w_life_load = r_life_load;
`else
    assign w_life_load = LIFE_INIT;
`endif

    assign molesGenerated = r_mask;
    assign spawnPulse     = r_spawn_pulse;
    assign expirePulse    = r_expire_pulse;
    assign activeCount    = w_count;

endmodule
